// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial adder/subtractor, one full-adder slice, LSB first
// Operands shift right through a registered carry; results land in registers on entry to DONE.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, ps_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, busy_q, done_q, cout_q, ovf_q;
  logic             bit_d, carry_d;
  logic [WIDTH-1:0] ps_d;

  assign bit_d   = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_d = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign ps_d    = {bit_d, ps_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert b and force the initial carry.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            c_q     <= sub | cin;
            cnt_q   <= '0;
            ps_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q  <= a_q >> 1;
          b_q  <= b_q >> 1;
          c_q  <= carry_d;
          ps_q <= ps_d;
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= ps_d;
            cout_q  <= carry_d;
            ovf_q   <= c_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised bit-serial adder/subtractor. It adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, using a single full-adder slice and a registered carry. It is the area-minimal sequential successor to the team's combinational 1-bit full adder, adding carry-in, subtract mode, signed-overflow detection and a start/done handshake. It sits in the datapath wherever a low-gate-count multi-cycle add is acceptable.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, no other clock domains
- start  in  1  request an operation; sampled only in IDLE or DONE
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- cin  in  1  carry-in for add; ignored when sub=1
- sub  in  1  0: a+b+cin, 1: a−b (a + ~b + 1); captured on the accepting edge
- busy  out  1  high while bits are being processed (RUN)
- done  out  1  high for exactly one cycle when a result becomes valid
- sum  out  WIDTH  result, low WIDTH bits
- cout  out  1  carry out of MSB; in subtract mode 1 = no borrow (a ≥ b unsigned)
- ovf  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge: capture a into the A shift register. Capture b, or ~b if sub=1, into the B shift register. Load the carry register with cin, or with 1 if sub=1. Clear the bit counter to 0. Go to RUN.
- RUN, each edge:
  - Bit s = A[0]^B[0]^c.
  - Next carry c = majority(A[0], B[0], c).
  - Shift s into the MSB of the partial-sum register (shifting right).
  - Shift A and B right by one.
  - Increment the counter.
- On the edge where the counter equals WIDTH−1 (the last bit):
  - Copy the completed partial sum into sum.
  - Set cout to the new carry.
  - Set ovf to the carry-in of this bit XOR the new carry.
  - Go to DONE.
- DONE lasts one cycle. The next state is RUN if start=1, otherwise IDLE.
- start in RUN is ignored; the operation is not restarted and no input is re-captured.
- sum, cout and ovf are result registers. They change only on entry to DONE and hold their value through IDLE and through any following RUN.
- a, b, cin and sub may change freely after the accepting edge.
- Counter width is clog2(WIDTH) bits. Counting from 0 to WIDTH−1 never wraps.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - All internal registers cleared.
- Deassertion of rst_n is assumed synchronous to clk.
- Latency, with start accepted at edge E0:
  - busy=1 from after E0 until after E_WIDTH.
  - done=1 and results valid in the cycle after E_WIDTH.
  - done=0 after E_(WIDTH+1).
- Throughput: start held high continuously gives one result every WIDTH+1 cycles. In that case busy drops for the single DONE cycle between operations.
- done and busy are never high in the same cycle.
- If reset is asserted mid-RUN, the operation is aborted. No done pulse is produced and the result registers read 0.
- Outputs are driven directly from registers, with no combinational path from inputs.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, sub=0, start pulsed one cycle.
  - busy high for 8 cycles, then done for 1 cycle.
  - sum=0x96, cout=0, ovf=1.
- Add with carry-in, a=0xFF, b=0x01, cin=1, sub=0.
  - sum=0x01, cout=1, ovf=0.
- Subtract, a=0x10, b=0x20, sub=1, cin=1 (must be ignored).
  - sum=0xF0, cout=0, ovf=0.
- Subtract, a=0x80, b=0x01, sub=1.
  - sum=0x7F, cout=1, ovf=1.
- Hold start=1 through two operations, (0x01+0x02) then (0x33+0x11). Change a and b during the first RUN.
  - First op: sum=0x03, captured operands unaffected by the mid-RUN change.
  - Second op: sum=0x44, done exactly 9 cycles after the first done.
  - Start pulses during RUN cause no restart.
- Start 0x5A+0x3C and assert rst_n low in RUN cycle 4.
  - All outputs go to 0 immediately and no done follows.
  - After reset release, 0x0F+0x01 gives sum=0x10, cout=0, ovf=0.
